l1_tag_lookup: RTL

L1_TAG_LOOKUP -- requirements
Module: l1_tag_lookup

---
 rtl/l1_tag_lookup_pkg.sv | 48 ++++
 rtl/l1_tag_lookup_tag_array.sv | 46 ++++
 rtl/l1_tag_lookup.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_tag_lookup_pkg.sv
// Shared definitions for the L1 tag lookup block: geometry defaults, derived
// widths, FSM state encoding and LRU transaction-type encoding.
package l1_tag_lookup_pkg;

  // Default cache geometry
  localparam int DEF_WAY             = 4;
  localparam int DEF_BLOCK_SIZE_BYTE = 16;
  localparam int DEF_CACHE_SIZE_BYTE = 32768;

  // Derived defaults
  localparam int DEF_SET       = DEF_CACHE_SIZE_BYTE / (DEF_BLOCK_SIZE_BYTE * DEF_WAY);
  localparam int DEF_SET_INDEX = $clog2(DEF_SET);
  localparam int DEF_OFFSET    = $clog2(DEF_BLOCK_SIZE_BYTE);
  localparam int DEF_TAG       = 32 - DEF_SET_INDEX - DEF_OFFSET;

  // Width of the 1-based way number handed to the LRU stage
  localparam int LRU_WAY_W = 5;

  // Lookup controller states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEARCH   = 3'd1,
    ST_LRU_REQ  = 3'd2,
    ST_LRU_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Kind of transaction reported to the LRU stage
  typedef enum logic [1:0] {
    LRU_NONE    = 2'd0,
    LRU_FOUND   = 2'd1,
    LRU_UPDATED = 2'd2,
    LRU_REPLACE = 2'd3
  } lru_type_e;

  // Decode a transaction type into {found, updated, replace} one-hot flags
  function automatic logic [2:0] lru_type_flags(input lru_type_e t);
    logic [2:0] f;
    case (t)
      LRU_FOUND:   f = 3'b100;
      LRU_UPDATED: f = 3'b010;
      LRU_REPLACE: f = 3'b001;
      default:     f = 3'b000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/l1_tag_lookup_tag_array.sv
// Valid + tag storage for the L1 cache: one combinational read port and one
// synchronous write port. Valid bits are cleared by reset; tags are not.
module l1_tag_array
  import l1_tag_lookup_pkg::*;
#(
  parameter int  SET       = DEF_SET,
  parameter int  WAY       = DEF_WAY,
  parameter int  TAG       = DEF_TAG,
  localparam int SET_INDEX = $clog2(SET),
  localparam int WAY_W     = (WAY > 1) ? $clog2(WAY) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SET_INDEX-1:0] rd_set,
  input  logic [WAY_W-1:0]     rd_way,
  output logic                 rd_valid,
  output logic [TAG-1:0]       rd_tag,
  input  logic                 wr_en,
  input  logic [SET_INDEX-1:0] wr_set,
  input  logic [WAY_W-1:0]     wr_way,
  input  logic [TAG-1:0]       wr_tag
);

  logic [SET-1:0][WAY-1:0] valid_r;
  logic [TAG-1:0]          tag_mem_r [SET][WAY];

  // Valid bits: cleared on reset, set by every array write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_set][wr_way] <= 1'b1;
    end
  end

  // Tag storage: no reset, written together with the valid bit
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem_r[wr_set][wr_way] <= wr_tag;
    end
  end

  assign rd_valid = valid_r[rd_set][rd_way];
  assign rd_tag   = tag_mem_r[rd_set][rd_way];

endmodule

// File: rtl/l1_tag_lookup.sv
// L1 tag lookup controller: latches a request, scans the ways of the indexed
// set one per cycle, classifies the access (found / updated / replace), hands
// it to the external LRU stage, applies the victim fill and reports hit/miss.
module l1_tag_lookup
  import l1_tag_lookup_pkg::*;
#(
  parameter int  WAY             = DEF_WAY,
  parameter int  BLOCK_SIZE_BYTE = DEF_BLOCK_SIZE_BYTE,
  parameter int  CACHE_SIZE_BYTE = DEF_CACHE_SIZE_BYTE,
  localparam int SET             = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
  localparam int SET_INDEX       = $clog2(SET),
  localparam int OFFSET          = $clog2(BLOCK_SIZE_BYTE),
  localparam int TAG             = 32 - SET_INDEX - OFFSET,
  localparam int WAY_W           = (WAY > 1) ? $clog2(WAY) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [31:0]          req_addr,
  output logic                 req_ready,
  output logic                 done,
  output logic                 hit,
  output logic                 miss,
  output logic                 lru_start,
  output logic [SET_INDEX-1:0] lru_index,
  output logic                 lru_found,
  output logic                 lru_updated,
  output logic                 lru_replace,
  output logic [LRU_WAY_W-1:0] lru_way,
  input  logic [LRU_WAY_W-1:0] lru_replace_index,
  input  logic                 lru_block_replace,
  input  logic                 lru_update_lru
);

  // FSM state
  state_e state_r;
  state_e state_s;

  // Latched request and search progress
  logic [TAG-1:0]       tag_r;
  logic [SET_INDEX-1:0] index_r;
  logic [WAY_W-1:0]     way_r;
  logic                 inv_found_r;
  logic [WAY_W-1:0]     inv_way_r;

  // Registered outputs
  logic                 req_ready_r;
  logic                 done_r;
  logic                 hit_r;
  logic                 miss_r;
  logic                 lru_start_r;
  logic [SET_INDEX-1:0] lru_index_r;
  logic                 lru_found_r;
  logic                 lru_updated_r;
  logic                 lru_replace_r;
  logic [LRU_WAY_W-1:0] lru_way_r;

  // Array read/write port signals
  logic                 rd_valid_s;
  logic [TAG-1:0]       rd_tag_s;
  logic                 wr_en_s;
  logic [WAY_W-1:0]     wr_way_s;

  // Control strobes from the next-state logic
  logic                 accept_s;
  logic                 search_end_s;
  lru_type_e            type_s;
  logic [WAY_W-1:0]     sel_way_s;
  logic                 lru_done_s;
  logic                 hit_now_s;
  logic                 last_way_s;
  logic                 victim_ok_s;

  // Offset bits never participate in the lookup
  logic [OFFSET-1:0]    unused_offset_s;
  assign unused_offset_s = req_addr[OFFSET-1:0];

  l1_tag_array #(
    .SET (SET),
    .WAY (WAY),
    .TAG (TAG)
  ) u_tag_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_set   (index_r),
    .rd_way   (way_r),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .wr_en    (wr_en_s),
    .wr_set   (index_r),
    .wr_way   (wr_way_s),
    .wr_tag   (tag_r)
  );

  assign hit_now_s   = rd_valid_s && (rd_tag_s == tag_r);
  assign last_way_s  = (way_r == WAY_W'(WAY - 1));
  // A victim number outside the array is dropped rather than aliased
  assign victim_ok_s = lru_block_replace && (lru_replace_index < LRU_WAY_W'(WAY));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic, search classification and array write control
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    search_end_s = 1'b0;
    type_s       = LRU_NONE;
    sel_way_s    = '0;
    wr_en_s      = 1'b0;
    wr_way_s     = '0;
    lru_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_s  = ST_SEARCH;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (hit_now_s) begin
          search_end_s = 1'b1;
          type_s       = LRU_FOUND;
          sel_way_s    = way_r;
          state_s      = ST_LRU_REQ;
        end else if (last_way_s) begin
          search_end_s = 1'b1;
          state_s      = ST_LRU_REQ;
          if (inv_found_r || !rd_valid_s) begin
            // Fill the lowest invalid way right away so a following
            // request to the same line already sees it
            type_s    = LRU_UPDATED;
            sel_way_s = inv_found_r ? inv_way_r : way_r;
            wr_en_s   = 1'b1;
            wr_way_s  = inv_found_r ? inv_way_r : way_r;
          end else begin
            type_s    = LRU_REPLACE;
          end
        end else begin
          state_s = ST_SEARCH;
        end
      end
      ST_LRU_REQ: begin
        state_s = ST_LRU_WAIT;
      end
      ST_LRU_WAIT: begin
        if (lru_update_lru) begin
          lru_done_s = 1'b1;
          state_s    = ST_DONE;
          if (lru_replace_r && victim_ok_s) begin
            wr_en_s  = 1'b1;
            wr_way_s = lru_replace_index[WAY_W-1:0];
          end else begin
            wr_en_s  = 1'b0;
          end
        end else begin
          state_s = ST_LRU_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Request latch and per-cycle way scan bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r       <= '0;
      index_r     <= '0;
      way_r       <= '0;
      inv_found_r <= 1'b0;
      inv_way_r   <= '0;
    end else if (accept_s) begin
      tag_r       <= req_addr[31:32-TAG];
      index_r     <= req_addr[OFFSET+SET_INDEX-1:OFFSET];
      way_r       <= '0;
      inv_found_r <= 1'b0;
      inv_way_r   <= '0;
    end else if (state_r == ST_SEARCH) begin
      way_r <= way_r + WAY_W'(1);
      if (!rd_valid_s && !inv_found_r) begin
        inv_found_r <= 1'b1;
        inv_way_r   <= way_r;
      end
    end
  end

  // Output registers, decoded from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r   <= 1'b1;
      done_r        <= 1'b0;
      hit_r         <= 1'b0;
      miss_r        <= 1'b0;
      lru_start_r   <= 1'b0;
      lru_index_r   <= '0;
      lru_found_r   <= 1'b0;
      lru_updated_r <= 1'b0;
      lru_replace_r <= 1'b0;
      lru_way_r     <= '0;
    end else begin
      req_ready_r <= (state_s == ST_IDLE);
      lru_start_r <= (state_s == ST_LRU_REQ);
      done_r      <= (state_s == ST_DONE);
      hit_r       <= (state_s == ST_DONE) && lru_found_r;
      miss_r      <= (state_s == ST_DONE) && !lru_found_r;
      if (search_end_s) begin
        {lru_found_r, lru_updated_r, lru_replace_r} <= lru_type_flags(type_s);
        lru_way_r   <= (type_s == LRU_REPLACE) ? LRU_WAY_W'(0)
                                               : (LRU_WAY_W'(sel_way_s) + LRU_WAY_W'(1));
        lru_index_r <= index_r;
      end else if (lru_done_s) begin
        {lru_found_r, lru_updated_r, lru_replace_r} <= 3'b000;
        lru_way_r <= '0;
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign done        = done_r;
  assign hit         = hit_r;
  assign miss        = miss_r;
  assign lru_start   = lru_start_r;
  assign lru_index   = lru_index_r;
  assign lru_found   = lru_found_r;
  assign lru_updated = lru_updated_r;
  assign lru_replace = lru_replace_r;
  assign lru_way     = lru_way_r;

endmodule
